apb_bus_arbiter: RTL and testbench
==================================

APB_BUS_ARBITER -- requirements
Module: apb_bus_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 255, max WAIT cycles without downstream ready before an error completion (legal 1..65535).
REQ-002 SHALL have port: PCLK  in  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port: PRESET  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: m0_transfer / m1_transfer  in  1  requester i asks for a bus access; held until mi_ready.
REQ-005 SHALL have ports: m0_write / m1_write  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports: m0_addr / m1_addr, m0_wdata / m1_wdata  in  32  access address and write data, stable while mi_transfer = 1.
REQ-007 SHALL have ports: m0_ready / m1_ready  out  1  one-cycle completion pulse to requester i.
REQ-008 SHALL have ports: m0_rdata / m1_rdata  out  32  read data, valid only while mi_ready = 1.
REQ-009 SHALL have ports: m0_err / m1_err  out  1  timeout flag, valid only while mi_ready = 1.
REQ-010 SHALL have ports: transfer  out  1; write  out  1; addr  out  32; wdata  out  32  request side of the APB master.
REQ-011 SHALL have ports: ready  in  1; rdata  in  32  completion side of the APB master.
REQ-012 SHALL have port: gnt  out  2  one-hot current owner (bit i = requester i), 2'b00 when idle.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-014 In IDLE with any mi_transfer = 1, SHALL select the owner, register its write/addr/wdata onto write/addr/wdata, set gnt, and go to ISSUE next cycle.
REQ-015 If both requesters are active in IDLE, SHALL grant the one not granted last; last-grant pointer resets to 1 so m0 wins the first tie.
REQ-016 In ISSUE SHALL drive transfer = 1 for exactly one cycle, then go to WAIT; transfer SHALL be 0 in every other state.
REQ-017 write/addr/wdata SHALL remain stable from ISSUE through the final WAIT cycle; later requester input changes are ignored.
REQ-018 ready SHALL be sampled only in WAIT; ready in IDLE or ISSUE is ignored.
REQ-019 In WAIT with ready = 1, SHALL drive the owner's mi_ready = 1, mi_rdata = rdata, mi_err = 0 in the same cycle (combinational), update last-grant, and go to IDLE.
REQ-020 SHALL clear the timeout counter on entry to WAIT and increment it each WAIT cycle with ready = 0.
REQ-021 When the counter equals TIMEOUT_CYC-1 and ready = 0, SHALL pulse the owner's mi_ready = 1 with mi_err = 1 and mi_rdata = 32'hDEAD_BEEF, update last-grant, and go to IDLE.
REQ-022 ready = 1 in the timeout cycle SHALL win: normal completion, err = 0.
REQ-023 The non-owner's m_ready, m_rdata and m_err SHALL be 0 at all times.
REQ-024 Minimum latency: mi_transfer rises in cycle N (IDLE) -> transfer in N+1 -> earliest mi_ready in N+2.
REQ-025 mi_transfer still high in the IDLE cycle after mi_ready SHALL count as a new request and take part in arbitration.
REQ-026 Owner dropping mi_transfer before completion SHALL NOT abort the access; mi_ready still pulses.
REQ-027 gnt SHALL return to 2'b00 on the cycle after completion.

Reset
REQ-028 While PRESET = 0: state = IDLE, transfer = write = 0, addr = wdata = 0, gnt = 0, all mi_ready/mi_err = 0, mi_rdata = 0, timeout counter = 0, last-grant = 1.
REQ-029 Reset asserted mid-access SHALL drop the access without any mi_ready pulse; first grant after release follows REQ-015.

Structure
REQ-030 Package apb_arb_pkg SHALL hold the state enum and the constant ARB_ERR_DATA = 32'hDEAD_BEEF.
REQ-031 The timeout counter SHALL be sub-module apb_arb_timeout (inputs clear, enable; output expired), counter width $clog2(TIMEOUT_CYC+1).

Verification
REQ-032 m0 only, read addr 0x1000_0004, ready in the 2nd WAIT cycle with rdata 0x0000_00A5 -> transfer one pulse, m0_ready once, m0_rdata 0x0000_00A5, m1_ready never.
REQ-033 Both request from reset, m0 write 0x11 to 0x1000_0000 and m1 write 0x22 to 0x1000_1000 -> m0 served first, then m1; gnt 01 then 10.
REQ-034 Both hold requests continuously for 6 accesses -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-035 TIMEOUT_CYC = 4, ready never asserted -> owner's mi_ready with err = 1 and rdata 0xDEAD_BEEF in the 4th WAIT cycle; ready on that 4th cycle -> err = 0.
REQ-036 PRESET low during WAIT for m1 -> no m1_ready; after release, both requesting -> m0 granted first, all outputs at reset values during reset.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB bus arbiter.
package apb_arb_pkg;

    // Arbiter sequencing: pick an owner, present the request for one cycle, wait for completion.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    // Read data returned to a requester whose access timed out.
    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_arb_timeout.sv
// Counts WAIT cycles without downstream ready; flags the last permitted cycle.
module apb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] r_count;

    assign expired = (r_count == LastCnt);

    // Counter clears on entry to WAIT and saturates at the expiry value.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Two-requester arbiter in front of a single APB master request/completion interface.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        m0_transfer,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_transfer,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        transfer,
    output logic        write,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        ready,
    input  logic [31:0] rdata,
    output logic [1:0]  gnt
);

    arb_state_e  r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_last, w_last_nxt;
    logic [1:0]  r_gnt, w_gnt_nxt;
    logic        r_write, w_write_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        w_expired;
    logic        w_done;
    logic        w_err;
    logic [31:0] w_rdata_mux;

    apb_arb_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clear  (r_state == StIssue),
        .enable ((r_state == StWait) && !ready),
        .expired(w_expired)
    );

    // State and captured-request registers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_write <= w_write_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Arbitration, request capture and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_write_nxt = r_write;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (m0_transfer || m1_transfer) begin
                    // On a tie the requester not served last wins.
                    if (m0_transfer && m1_transfer) begin
                        w_owner_nxt = ~r_last;
                    end else begin
                        w_owner_nxt = m1_transfer;
                    end
                    w_write_nxt = w_owner_nxt ? m1_write : m0_write;
                    w_addr_nxt  = w_owner_nxt ? m1_addr  : m0_addr;
                    w_wdata_nxt = w_owner_nxt ? m1_wdata : m0_wdata;
                    w_gnt_nxt   = w_owner_nxt ? 2'b10 : 2'b01;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_state_nxt = StWait;
            end
            StWait: begin
                // A real ready in the expiry cycle takes priority over the timeout.
                if (ready) begin
                    w_done = 1'b1;
                end else if (w_expired) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end
                if (w_done) begin
                    w_last_nxt  = r_owner;
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign transfer    = (r_state == StIssue);
    assign write       = r_write;
    assign addr        = r_addr;
    assign wdata       = r_wdata;
    assign gnt         = r_gnt;
    assign w_rdata_mux = w_err ? ARB_ERR_DATA : rdata;

    // Completion is steered only to the owner; the other requester sees zeros.
    assign m0_ready = w_done && !r_owner;
    assign m1_ready = w_done && r_owner;
    assign m0_rdata = m0_ready ? w_rdata_mux : 32'h0;
    assign m1_rdata = m1_ready ? w_rdata_mux : 32'h0;
    assign m0_err   = m0_ready && w_err;
    assign m1_err   = m1_ready && w_err;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench: tests queue expected completions, a monitor checks each ready pulse.
module tb_apb_bus_arbiter;

    localparam int unsigned TO = 4;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          k;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic [1:0]  tr, wr;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic        ready;
    logic [31:0] rdata;
    logic [1:0]  gnt;

    exp_t        expq[$];
    req_t        q0[$];
    req_t        q1[$];
    int          errors = 0;
    int          checks = 0;
    int          slave_delay = 1;
    logic [31:0] slave_rdata = 32'h0;

    always #5 PCLK = ~PCLK;

    apb_bus_arbiter #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .m0_transfer(tr[0]),
        .m0_write   (wr[0]),
        .m0_addr    (ad[0]),
        .m0_wdata   (wd[0]),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m0_err     (m0_err),
        .m1_transfer(tr[1]),
        .m1_write   (wr[1]),
        .m1_addr    (ad[1]),
        .m1_wdata   (wd[1]),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .m1_err     (m1_err),
        .transfer   (transfer),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rdata      (rdata),
        .gnt        (gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.wr = w; r.addr = a; r.wdata = d;
        if (p == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic push_exp(input int p, input logic [31:0] rd, input logic e, input int k,
                            input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        x.port = p; x.rdata = rd; x.err = e; x.k = k; x.wr = w; x.addr = a; x.wdata = d;
        expq.push_back(x);
    endtask

    // Requester model: holds transfer until its ready, back-to-back if more work is queued.
    task automatic requester(input int p);
        req_t r;
        int   n;
        logic got;
        forever begin
            @(posedge PCLK); #1;
            if (!PRESET) begin
                tr[p] = 1'b0;
                continue;
            end
            if ((p == 0 ? q0.size() : q1.size()) > 0) begin
                if (p == 0) r = q0.pop_front(); else r = q1.pop_front();
                wr[p] = r.wr; ad[p] = r.addr; wd[p] = r.wdata; tr[p] = 1'b1;
                n = 0;
                got = 1'b0;
                while (!got && PRESET && n < 50) begin
                    @(negedge PCLK);
                    n++;
                    got = (p == 0) ? m0_ready : m1_ready;
                end
                if (!PRESET) tr[p] = 1'b0;
                else if (!got) begin
                    fail_now($sformatf("req%0d_no_ready got none within 50 cycles expected a ready", p));
                    tr[p] = 1'b0;
                end
            end else begin
                tr[p] = 1'b0;
            end
        end
    endtask

    // Downstream slave: answers in WAIT cycle slave_delay (0 = never).
    task automatic slave();
        forever begin
            @(posedge PCLK); #1;
            if (PRESET && transfer) begin
                for (int k = 1; k <= int'(TO); k++) begin
                    @(posedge PCLK); #1;
                    if (!PRESET) break;
                    if (k == slave_delay) begin
                        ready = 1'b1;
                        rdata = slave_rdata;
                        @(posedge PCLK); #1;
                        ready = 1'b0;
                        rdata = 32'h0;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        int   tcnt = 0;
        int   wcnt = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (!PRESET) begin
                tcnt = 0; wcnt = 0; prev_done = 1'b0;
                continue;
            end
            if (prev_done) chk("gnt_after_done", {30'h0, gnt}, 32'h0);
            prev_done = 1'b0;
            if (transfer) begin
                tcnt++;
                wcnt = 0;
            end else if (gnt != 2'b00) begin
                wcnt++;
            end
            if (m0_ready || m1_ready) begin
                prev_done = 1'b1;
                if (m0_ready && m1_ready) begin
                    fail_now("both_ready got both readys expected one");
                end else if (expq.size() == 0) begin
                    fail_now($sformatf("unexpected_ready got m%0d_ready expected none",
                                       m1_ready ? 1 : 0));
                end else begin
                    e = expq.pop_front();
                    chk("owner", m1_ready ? 32'd1 : 32'd0, e.port);
                    if (e.port == 0) begin
                        chk("m0_rdata", m0_rdata, e.rdata);
                        chk("m0_err", {31'h0, m0_err}, {31'h0, e.err});
                        chk("m1_quiet", {m1_rdata[31:1], m1_rdata[0] | m1_err}, 32'h0);
                    end else begin
                        chk("m1_rdata", m1_rdata, e.rdata);
                        chk("m1_err", {31'h0, m1_err}, {31'h0, e.err});
                        chk("m0_quiet", {m0_rdata[31:1], m0_rdata[0] | m0_err}, 32'h0);
                    end
                    chk("gnt_owner", {30'h0, gnt}, e.port == 0 ? 32'd1 : 32'd2);
                    chk("wait_cycles", wcnt, e.k);
                    chk("transfer_pulses", tcnt, 32'd1);
                    chk("addr", addr, e.addr);
                    chk("write", {31'h0, write}, {31'h0, e.wr});
                    chk("wdata", wdata, e.wdata);
                end
                tcnt = 0;
            end else begin
                chk("quiet_rdata", m0_rdata | m1_rdata, 32'h0);
                chk("quiet_err", {30'h0, m0_err, m1_err}, 32'h0);
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_transfer", {31'h0, transfer}, 32'h0);
        chk("rst_write", {31'h0, write}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_gnt", {30'h0, gnt}, 32'h0);
        chk("rst_ready", {30'h0, m0_ready, m1_ready}, 32'h0);
        chk("rst_err", {30'h0, m0_err, m1_err}, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        check_reset_outputs();
    endtask

    task automatic release_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() > 0 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (expq.size() > 0) begin
            fail_now($sformatf("drain got %0d pending expected 0", expq.size()));
            expq.delete();
        end
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        int n;
        tr = 2'b00; wr = 2'b00;
        ad[0] = 32'h0; ad[1] = 32'h0; wd[0] = 32'h0; wd[1] = 32'h0;
        ready = 1'b0; rdata = 32'h0;
        fork
            requester(0);
            requester(1);
            slave();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(negedge PCLK);
        check_reset_outputs();
        release_reset();

        // m0 single read, ready in the 2nd WAIT cycle
        slave_delay = 2; slave_rdata = 32'h0000_00A5;
        push_exp(0, 32'h0000_00A5, 1'b0, 2, 1'b0, 32'h1000_0004, 32'h0);
        push_req(0, 1'b0, 32'h1000_0004, 32'h0);
        drain();

        // Tie from reset: m0 first, then m1
        apply_reset();
        release_reset();
        slave_delay = 1; slave_rdata = 32'h0000_005A;
        push_exp(0, 32'h0000_005A, 1'b0, 1, 1'b1, 32'h1000_0000, 32'h11);
        push_exp(1, 32'h0000_005A, 1'b0, 1, 1'b1, 32'h1000_1000, 32'h22);
        push_req(0, 1'b1, 32'h1000_0000, 32'h11);
        push_req(1, 1'b1, 32'h1000_1000, 32'h22);
        drain();

        // Continuous contention alternates owners
        slave_delay = 3; slave_rdata = 32'h0000_003C;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 32'h0000_003C, 1'b0, 3, 1'b0, 32'h2000_0000 + 32'(i * 4), 32'h0);
            push_exp(1, 32'h0000_003C, 1'b0, 3, 1'b1, 32'h3000_0000 + 32'(i * 4), 32'(i + 1));
            push_req(0, 1'b0, 32'h2000_0000 + 32'(i * 4), 32'h0);
            push_req(1, 1'b1, 32'h3000_0000 + 32'(i * 4), 32'(i + 1));
        end
        drain();

        // Timeout in the 4th WAIT cycle, then ready exactly on that cycle wins
        slave_delay = 0;
        push_exp(0, 32'hDEAD_BEEF, 1'b1, 4, 1'b0, 32'h4000_0000, 32'h0);
        push_req(0, 1'b0, 32'h4000_0000, 32'h0);
        drain();
        slave_delay = 4; slave_rdata = 32'h0000_0077;
        push_exp(1, 32'h0000_0077, 1'b0, 4, 1'b0, 32'h4000_0010, 32'h0);
        push_req(1, 1'b0, 32'h4000_0010, 32'h0);
        drain();

        // m0 served last, then m1 aborted by reset mid-WAIT
        slave_delay = 1; slave_rdata = 32'h0000_0099;
        push_exp(0, 32'h0000_0099, 1'b0, 1, 1'b0, 32'h5000_0000, 32'h0);
        push_req(0, 1'b0, 32'h5000_0000, 32'h0);
        drain();
        slave_delay = 0;
        push_req(1, 1'b0, 32'h5000_0100, 32'h0);
        n = 0;
        while (!(gnt == 2'b10 && !transfer) && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("m1_reached_wait", {30'h0, gnt}, 32'd2);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        check_reset_outputs();
        slave_delay = 1; slave_rdata = 32'h0000_0042;
        push_exp(0, 32'h0000_0042, 1'b0, 1, 1'b1, 32'h6000_0000, 32'hAA);
        push_exp(1, 32'h0000_0042, 1'b0, 1, 1'b1, 32'h6000_0004, 32'hBB);
        push_req(0, 1'b1, 32'h6000_0000, 32'hAA);
        push_req(1, 1'b1, 32'h6000_0004, 32'hBB);
        release_reset();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
